multi_cycle_control_112: RTL
============================

// Module: multi_cycle_control_112
// PURPOSE
//  Moore FSM sequencing a multi-cycle MIPS datapath (shared memory, IR, A/B/ALUOut regs) for R-type, ori, lw, sw, beq, j.
//  Replaces the single-cycle main decoder with per-state control. Waits on a memory ready handshake.
//  Counts retired instructions and flags unsupported opcodes.
// PARAMETERS
//  CNT_W    16   width of retired-instruction counter instr_cnt (wraps modulo 2^CNT_W)
// PORTS
//  clk        in   1      system clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  op         in   6      IR[31:26]; sampled in ID state only
//  mem_ready  in   1      memory completes current read/write this cycle
//  PCWr       out  1      unconditional PC write
//  PCWrCond   out  1      PC write if ALU zero (beq)
//  IorD       out  1      0: mem addr=PC, 1: mem addr=ALUOut
//  MemRd      out  1      memory read request
//  MemWr      out  1      memory write request
//  IRWr       out  1      instruction register load
//  RegDst     out  1      1: rd, 0: rt
//  RegWr      out  1      register file write
//  MemtoReg   out  1      1: write-back from MDR, 0: from ALUOut
//  ALUSrcA    out  1      0: PC, 1: reg A
//  ALUSrcB    out  2      00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
//  ALUop      out  3      000 add, 100 sub, 010 or, 001 R-type (funct decode)
//  ExtOp      out  1      1 sign-extend, 0 zero-extend
//  PCSrc      out  2      00 ALU result, 01 ALUOut, 10 jump target
//  illegal_op out  1      1-cycle pulse in ID when op unsupported
//  instr_cnt  out  CNT_W  retired-instruction count
//  state      out  4      current state (debug)
// BEHAVIOUR
//  Encodings: R 000000, ori 001101, lw 100011, sw 101011, beq 000100, j 000010.
//  States: IF=0 ID=1 MADR=2 MRD=3 MWB=4 MWR=5 REX=6 RWB=7 BR=8 JMP=9 OEX=10 OWB=11; 12-15 -> IF next cycle.
//  rst=1: state<=IF, instr_cnt<=0. All control outputs, including illegal_op, are forced to 0 while rst=1.
//  Outputs are combinational in state (plus mem_ready where noted). Unlisted outputs are 0.
//  IF:   MemRd=1 IorD=0 ALUSrcA=0 ALUSrcB=01 ALUop=000 PCSrc=00.
//        IRWr=PCWr=mem_ready. Stay in IF while mem_ready=0; go to ID when 1.
//  ID:   ALUSrcA=0 ALUSrcB=11 ALUop=000 ExtOp=1 (branch target to ALUOut).
//        op lw/sw->MADR, R->REX, ori->OEX, beq->BR, j->JMP. Any other op: illegal_op=1, ->IF.
//  MADR: ALUSrcA=1 ALUSrcB=10 ALUop=000 ExtOp=1; lw->MRD, sw->MWR (op stable from IR).
//  MRD:  MemRd=1 IorD=1; hold until mem_ready=1, then ->MWB.
//  MWB:  RegWr=1 MemtoReg=1 RegDst=0; ->IF.
//  MWR:  MemWr=1 IorD=1; held every cycle until mem_ready=1, then ->IF. Exactly one write completes.
//  REX:  ALUSrcA=1 ALUSrcB=00 ALUop=001; ->RWB.
//  RWB:  RegDst=1 RegWr=1; ->IF.
//  BR:   ALUSrcA=1 ALUSrcB=00 ALUop=100 PCWrCond=1 PCSrc=01; ->IF.
//  JMP:  PCWr=1 PCSrc=10; ->IF.
//  OEX:  ALUSrcA=1 ALUSrcB=10 ALUop=010 ExtOp=0; ->OWB.
//  OWB:  RegWr=1 RegDst=0 MemtoReg=0; ->IF.
//  Retire: instr_cnt+=1 on the last-state exit of MWB, MWR(with mem_ready), RWB, BR, JMP, OWB.
//        Illegal op does not retire. Counter wraps to 0.
//  Latency with mem_ready=1: lw 5, sw/R/ori 4, beq/j 3 cycles.
//  rst mid-instruction aborts it. No retire, no pending write; MemWr drops in the cycle rst is high.
// TESTING
//  1 rst 2 cycles, op=100011, mem_ready=1 -> states 0,1,2,3,4.
//    MemtoReg=RegWr=1 in state 4; instr_cnt=1 after.
//  2 op=000000 -> 0,1,6,7. ALUop=001 in 6; RegDst=RegWr=1 in 7; 4 cycles total.
//  3 op=101011, mem_ready low 3 cycles in MWR -> MemWr=1 for 4 cycles, then IF.
//    instr_cnt increments once.
//  4 op=000100 -> BR: PCWrCond=1 ALUop=100 PCSrc=01.
//    op=000010 -> JMP: PCWr=1 PCSrc=10. Each 3 cycles.
//  5 op=111111 -> illegal_op=1 one cycle in ID, next state IF, instr_cnt unchanged.
//    op=001101 -> ALUop=010 ExtOp=0 in OEX.
//  6 rst in MRD -> next state IF, all outputs 0 during rst, instr_cnt=0.
//    CNT_W=4, 16 j instructions -> instr_cnt wraps to 0.

Source files
------------

// File: rtl/multi_cycle_control_112_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// Handshake: mem_ready is a completion strobe from memory. A read or write
// request (MemRd/MemWr) is held high every cycle until a cycle in which
// mem_ready=1 is seen; that cycle is the one in which the access completes.
// There is no backpressure from the controller toward memory.
interface multi_cycle_control_112_if #(
    parameter int CNT_W = 16
);
    // datapath -> controller
    logic [5:0]       op;
    logic             mem_ready;

    // controller -> datapath
    logic             PCWr;
    logic             PCWrCond;
    logic             IorD;
    logic             MemRd;
    logic             MemWr;
    logic             IRWr;
    logic             RegDst;
    logic             RegWr;
    logic             MemtoReg;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUop;
    logic             ExtOp;
    logic [1:0]       PCSrc;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_cnt;
    logic [3:0]       state;

    // controller side
    modport master (
        input  op,
        input  mem_ready,
        output PCWr,
        output PCWrCond,
        output IorD,
        output MemRd,
        output MemWr,
        output IRWr,
        output RegDst,
        output RegWr,
        output MemtoReg,
        output ALUSrcA,
        output ALUSrcB,
        output ALUop,
        output ExtOp,
        output PCSrc,
        output illegal_op,
        output instr_cnt,
        output state
    );

    // datapath / memory side
    modport slave (
        output op,
        output mem_ready,
        input  PCWr,
        input  PCWrCond,
        input  IorD,
        input  MemRd,
        input  MemWr,
        input  IRWr,
        input  RegDst,
        input  RegWr,
        input  MemtoReg,
        input  ALUSrcA,
        input  ALUSrcB,
        input  ALUop,
        input  ExtOp,
        input  PCSrc,
        input  illegal_op,
        input  instr_cnt,
        input  state
    );
endinterface

// File: rtl/multi_cycle_control_112.sv
// Moore control FSM for a multi-cycle MIPS datapath (R-type, ori, lw, sw,
// beq, j). Outputs are decoded from the current state, with mem_ready
// qualifying the fetch strobes. Retired instructions are counted and
// unsupported opcodes produce a one-cycle illegal_op pulse in decode.
module multi_cycle_control_112 #(
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    multi_cycle_control_112_if.master     bus
);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REX  = 4'd6,
        S_RWB  = 4'd7,
        S_BR   = 4'd8,
        S_JMP  = 4'd9,
        S_OEX  = 4'd10,
        S_OWB  = 4'd11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    logic             pc_wr;
    logic             pc_wr_cond;
    logic             i_or_d;
    logic             mem_rd;
    logic             mem_wr;
    logic             ir_wr;
    logic             reg_dst;
    logic             reg_wr;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             ext_op;
    logic [1:0]       pc_src;
    logic             illegal;

    // State register and retired-instruction counter; reset aborts any
    // in-flight instruction without retiring it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    // Next-state, per-state control decode and retire strobe.
    always_comb begin
        state_d    = S_IF;
        retire     = 1'b0;
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        i_or_d     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_dst    = 1'b0;
        reg_wr     = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        ext_op     = 1'b0;
        pc_src     = 2'b00;
        illegal    = 1'b0;

        case (state_q)
            S_IF: begin
                // Fetch and PC+4 share the cycle in which memory answers.
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_wr     = bus.mem_ready;
                pc_wr     = bus.mem_ready;
                state_d   = bus.mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                // Speculative branch target PC + (sext(imm) << 2) into ALUOut.
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MADR;
                    OP_R:         state_d = S_REX;
                    OP_ORI:       state_d = S_OEX;
                    OP_BEQ:       state_d = S_BR;
                    OP_J:         state_d = S_JMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_IF;
                    end
                endcase
            end
            S_MADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                state_d   = (bus.op == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                mem_rd  = 1'b1;
                i_or_d  = 1'b1;
                state_d = bus.mem_ready ? S_MWB : S_MRD;
            end
            S_MWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_IF;
            end
            S_MWR: begin
                // Write request stays asserted until memory accepts it.
                mem_wr  = 1'b1;
                i_or_d  = 1'b1;
                retire  = bus.mem_ready;
                state_d = bus.mem_ready ? S_IF : S_MWR;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_dst = 1'b1;
                reg_wr  = 1'b1;
                retire  = 1'b1;
                state_d = S_IF;
            end
            S_BR: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b100;
                pc_wr_cond = 1'b1;
                pc_src     = 2'b01;
                retire     = 1'b1;
                state_d    = S_IF;
            end
            S_JMP: begin
                pc_wr   = 1'b1;
                pc_src  = 2'b10;
                retire  = 1'b1;
                state_d = S_IF;
            end
            S_OEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b010;
                state_d   = S_OWB;
            end
            S_OWB: begin
                reg_wr  = 1'b1;
                retire  = 1'b1;
                state_d = S_IF;
            end
            default: begin
                // Unused encodings recover to fetch with all controls idle.
                state_d = S_IF;
            end
        endcase
    end

    // Reset silences every control strobe in the same cycle it is high,
    // so a pending memory write is dropped immediately.
    always_comb begin
        bus.PCWr       = pc_wr      & ~rst;
        bus.PCWrCond   = pc_wr_cond & ~rst;
        bus.IorD       = i_or_d     & ~rst;
        bus.MemRd      = mem_rd     & ~rst;
        bus.MemWr      = mem_wr     & ~rst;
        bus.IRWr       = ir_wr      & ~rst;
        bus.RegDst     = reg_dst    & ~rst;
        bus.RegWr      = reg_wr     & ~rst;
        bus.MemtoReg   = mem_to_reg & ~rst;
        bus.ALUSrcA    = alu_src_a  & ~rst;
        bus.ALUSrcB    = rst ? 2'b00  : alu_src_b;
        bus.ALUop      = rst ? 3'b000 : alu_op;
        bus.ExtOp      = ext_op     & ~rst;
        bus.PCSrc      = rst ? 2'b00  : pc_src;
        bus.illegal_op = illegal    & ~rst;
    end

    assign bus.instr_cnt = cnt_q;
    assign bus.state     = state_q;

endmodule
